// File: rtl/execute_cycle.sv
// Execute stage of the five-stage RV32 pipeline.
// Operand forwarding, ALU, branch resolution and the E/M register.
module execute_cycle (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteE,
  input  logic        ALUSrcE,
  input  logic        MemWriteE,
  input  logic        ResultSrcE,
  input  logic        BranchE,
  input  logic [2:0]  ALUControlE,
  input  logic [31:0] RD1_E,
  input  logic [31:0] RD2_E,
  input  logic [31:0] Imm_Ext_E,
  input  logic [31:0] PCE,
  input  logic [31:0] PCPlus4E,
  input  logic [4:0]  RD_E,
  input  logic [1:0]  ForwardA_E,
  input  logic [1:0]  ForwardB_E,
  input  logic [31:0] ResultW,
  output logic        PCSrcE,
  output logic [31:0] PCTargetE,
  output logic        RegWriteM,
  output logic        MemWriteM,
  output logic        ResultSrcM,
  output logic [4:0]  RD_M,
  output logic [31:0] ALUResultM,
  output logic [31:0] WriteDataM,
  output logic [31:0] PCPlus4M
);

  logic [31:0] src_a;
  logic [31:0] fwd_b;
  logic [31:0] src_b;
  logic [31:0] alu_result;
  logic        zero;

  // 10 selects the value currently held in our own E/M register
  always_comb begin
    src_a = RD1_E;
    unique case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUResultM;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    fwd_b = RD2_E;
    unique case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALUResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b = ALUSrcE ? Imm_Ext_E : fwd_b;

  always_comb begin
    alu_result = '0;
    unique case (ALUControlE)
      3'b000:  alu_result = src_a + src_b;
      3'b001:  alu_result = src_a - src_b;
      3'b010:  alu_result = src_a & src_b;
      3'b011:  alu_result = src_a | src_b;
      3'b101:  alu_result = {31'd0, $signed(src_a) < $signed(src_b)};
      default: alu_result = '0;
    endcase
  end

  assign zero      = (alu_result == 32'd0);
  assign PCSrcE    = BranchE & zero;
  assign PCTargetE = PCE + Imm_Ext_E;

  // WriteDataM takes the forwarded B before the immediate mux (store data)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      RD_M       <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
    end else begin
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RD_M       <= RD_E;
      ALUResultM <= alu_result;
      WriteDataM <= fwd_b;
      PCPlus4M   <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed bench for execute_cycle.
// Hand-computed vectors for ALU, forwarding, branch and reset.
module tb_execute_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E;
  logic [1:0]  ForwardA_E, ForwardB_E;
  logic [31:0] ResultW;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

  int n_cmp = 0;
  int n_bad = 0;

  execute_cycle dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE),
    .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E),
    .Imm_Ext_E(Imm_Ext_E), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .RD_E(RD_E),
    .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
    .ResultW(ResultW), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    RegWriteE = 0; ALUSrcE = 0; MemWriteE = 0;
    ResultSrcE = 0; BranchE = 0; ALUControlE = 3'b000;
    RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; PCE = 0;
    PCPlus4E = 0; RD_E = 0; ForwardA_E = 0;
    ForwardB_E = 0; ResultW = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_m_zero(input string tag);
    check({tag, "_regw"}, {31'd0, RegWriteM}, 0);
    check({tag, "_memw"}, {31'd0, MemWriteM}, 0);
    check({tag, "_rsrc"}, {31'd0, ResultSrcM}, 0);
    check({tag, "_rd"}, {27'd0, RD_M}, 0);
    check({tag, "_alu"}, ALUResultM, 0);
    check({tag, "_wd"}, WriteDataM, 0);
    check({tag, "_pc4"}, PCPlus4M, 0);
  endtask

  initial begin
    idle();
    rst = 0;
    RD1_E = 5; RD2_E = 7; RegWriteE = 1; RD_E = 3;
    PCPlus4E = 32'h44; PCE = 32'h100; Imm_Ext_E = 4;
    #2;
    check_m_zero("rst0");
    check("rst_pctgt", PCTargetE, 32'h104);
    step(); step();
    check_m_zero("rst_clk");

    // release between edges; first edge loads the add
    #2 rst = 1;
    PCE = 0; Imm_Ext_E = 0;
    step();
    check("add_alu", ALUResultM, 12);
    check("add_regw", {31'd0, RegWriteM}, 1);
    check("add_rd", {27'd0, RD_M}, 3);
    check("add_wd", WriteDataM, 7);
    check("add_pc4", PCPlus4M, 32'h44);

    // chain: 12 - 1 via ALUResultM forward
    ForwardA_E = 2'b10; RD2_E = 1; ALUControlE = 3'b001;
    step();
    check("fwdA_alu", ALUResultM, 11);
    check("fwdA_wd", WriteDataM, 1);

    // chain again: 11 - ResultW(9)
    ForwardB_E = 2'b01; ResultW = 9;
    step();
    check("fwdB_alu", ALUResultM, 2);
    check("fwdB_wd", WriteDataM, 9);

    // ForwardA 11 behaves as 00
    ForwardA_E = 2'b11; ForwardB_E = 2'b10;
    RD1_E = 20; ALUControlE = 3'b000;
    step();
    check("fwd11_alu", ALUResultM, 22);
    check("fwd10b_wd", WriteDataM, 2);

    // signed slt and add wrap
    idle();
    RD1_E = 32'hFFFF_FFFF; RD2_E = 1; ALUControlE = 3'b101;
    BranchE = 1;
    #1 check("slt_zero", {31'd0, PCSrcE}, 0);
    step();
    check("slt_neg", ALUResultM, 1);
    ALUControlE = 3'b000;
    #1 check("wrap_zero", {31'd0, PCSrcE}, 1);
    step();
    check("wrap_alu", ALUResultM, 0);
    RD1_E = 2; RD2_E = 32'hFFFF_FFFF; ALUControlE = 3'b101;
    step();
    check("slt_pos", ALUResultM, 0);

    // logic ops and unused codes
    BranchE = 0;
    RD1_E = 32'h0000_F0F0; RD2_E = 32'h0000_FF00;
    ALUControlE = 3'b010;
    step();
    check("and", ALUResultM, 32'h0000_F000);
    ALUControlE = 3'b011;
    step();
    check("or", ALUResultM, 32'h0000_FFF0);
    ALUControlE = 3'b100;
    step();
    check("op100", ALUResultM, 0);
    ALUControlE = 3'b111;
    step();
    check("op111", ALUResultM, 0);

    // beq taken / not taken, backward target
    idle();
    BranchE = 1; RD1_E = 32'h20; RD2_E = 32'h20;
    ALUControlE = 3'b001; PCE = 32'h100;
    Imm_Ext_E = 32'hFFFF_FFF8;
    #1;
    check("beq_taken", {31'd0, PCSrcE}, 1);
    check("beq_tgt", PCTargetE, 32'hF8);
    RD2_E = 32'h21;
    #1 check("beq_ntaken", {31'd0, PCSrcE}, 0);
    BranchE = 0; RD2_E = 32'h20;
    #1 check("nobranch", {31'd0, PCSrcE}, 0);

    // store: immediate feeds ALU, RD2 goes to write data
    idle();
    ALUSrcE = 1; Imm_Ext_E = 32'h10; RD1_E = 4;
    RD2_E = 32'hAB; MemWriteE = 1; ResultSrcE = 1;
    PCPlus4E = 32'h204; RD_E = 9;
    step();
    check("st_alu", ALUResultM, 32'h14);
    check("st_wd", WriteDataM, 32'hAB);
    check("st_memw", {31'd0, MemWriteM}, 1);
    check("st_rsrc", {31'd0, ResultSrcM}, 1);
    check("st_pc4", PCPlus4M, 32'h204);

    // async reset mid-cycle with live data
    #2 rst = 0;
    #1 check_m_zero("mid_rst");
    idle();
    RD1_E = 1; RD2_E = 2; RD_E = 5; RegWriteE = 1;
    PCE = 32'h40; Imm_Ext_E = 32'h8;
    #1 check("rst_tgt_comb", PCTargetE, 32'h48);
    #1 rst = 1;
    step();
    check("rel_alu", ALUResultM, 3);
    check("rel_rd", {27'd0, RD_M}, 5);
    check("rel_wd", WriteDataM, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
